// File: rtl/pipelined_bypass_adder_if.sv
// Operand/result bus with valid/ready handshakes on both sides of the
// pipelined bypass adder. The master drives operands and accepts results;
// the slave (the adder) consumes operands and presents results.
interface pipelined_bypass_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-skip adder/subtractor.
// The operand width is cut into STAGES segments of SEG bits. Stage s adds
// segment s using the carry registered by stage s-1, so only one segment's
// carry-skip chain sits between any two registers. Operand bits for later
// segments travel forward in skew registers that shrink stage by stage,
// while finished sum bits travel forward in deskew registers that grow
// stage by stage, so every bit of one beat leaves the last stage together.
// A single global stall (advance) freezes every stage at once.
module pipelined_bypass_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 4
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_bypass_adder_if.slave bus
);

  localparam int SEG    = WIDTH / STAGES;
  localparam int GROUPS = SEG / BLOCK;

  logic             advance;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  // One segment of carry-skip addition. Each BLOCK-bit group ripples its
  // sum bits; the group carry-out bypasses the ripple chain whenever every
  // bit of the group propagates, so a long propagate run costs one mux per
  // group instead of BLOCK full-adder delays.
  function automatic logic [SEG:0] skip_add(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           cin);
    logic [SEG-1:0] acc;
    logic           carry;
    logic           ripple;
    logic           prop;
    acc   = '0;
    carry = cin;
    for (int g = 0; g < GROUPS; g++) begin
      ripple = carry;
      prop   = 1'b1;
      for (int k = 0; k < BLOCK; k++) begin
        acc[g*BLOCK+k] = a[g*BLOCK+k] ^ b[g*BLOCK+k] ^ ripple;
        ripple         = (a[g*BLOCK+k] & b[g*BLOCK+k]) |
                         (ripple & (a[g*BLOCK+k] ^ b[g*BLOCK+k]));
        prop           = prop & (a[g*BLOCK+k] ^ b[g*BLOCK+k]);
      end
      carry = prop ? carry : ripple;
    end
    return {carry, acc};
  endfunction

  // Subtraction is A + ~B + 1, so Sub forces the carry-in and inverts B
  // before anything is registered; Cin only matters in add mode.
  always_comb begin
    eff_b   = bus.Sub ? ~bus.B : bus.B;
    eff_cin = bus.Sub | bus.Cin;
  end

  // The whole pipe moves only when the output slot is empty or being taken.
  // in_ready depends on the output side alone, never on in_valid.
  assign advance      = !stage_g[STAGES-1].valid_r || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : stage_g
    localparam int LO = s * SEG;

    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                c_in;
    logic                v_in;
    logic [SEG:0]        seg_res;
    logic [LO+SEG-1:0]   sum_next;
    logic                valid_r;
    logic                carry_r;
    logic [LO+SEG-1:0]   sum_r;

    if (s == 0) begin : src_g
      assign a_in     = bus.A;
      assign b_in     = eff_b;
      assign c_in     = eff_cin;
      assign v_in     = bus.in_valid;
      assign sum_next = seg_res[SEG-1:0];
    end else begin : src_g
      assign a_in     = stage_g[s-1].op_g.a_r;
      assign b_in     = stage_g[s-1].op_g.b_r;
      assign c_in     = stage_g[s-1].carry_r;
      assign v_in     = stage_g[s-1].valid_r;
      assign sum_next = {seg_res[SEG-1:0], stage_g[s-1].sum_r};
    end

    assign seg_res = skip_add(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

    // Stage register: valid bit always shifts on advance; data only loads
    // for a real beat so bubbles leave the previous result untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (advance) begin
        valid_r <= v_in;
        if (v_in) begin
          carry_r <= seg_res[SEG];
          sum_r   <= sum_next;
        end
      end
    end

    if (s < STAGES-1) begin : op_g
      logic [WIDTH-LO-SEG-1:0] a_r;
      logic [WIDTH-LO-SEG-1:0] b_r;

      // Skew registers: carry the not-yet-added operand bits to the next
      // stage. They are pure datapath and are qualified by valid_r, so
      // they need no reset.
      always_ff @(posedge clk) begin
        if (advance && v_in) begin
          a_r <= a_in[WIDTH-LO-1:SEG];
          b_r <= b_in[WIDTH-LO-1:SEG];
        end
      end
    end

    if (s == STAGES-1) begin : last_g
      logic c_msb;
      logic ovf_r;

      // The carry into the MSB is recovered from the MSB sum bit and its
      // operand bits, so no extra carry has to be exported by skip_add.
      assign c_msb = seg_res[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1];

      // Signed overflow register, loaded alongside the final segment.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance && v_in) begin
          ovf_r <= c_msb ^ seg_res[SEG];
        end
      end
    end
  end

  assign bus.out_valid = stage_g[STAGES-1].valid_r;
  assign bus.Sum       = stage_g[STAGES-1].sum_r;
  assign bus.Cout      = stage_g[STAGES-1].carry_r;
  assign bus.Ovf       = stage_g[STAGES-1].last_g.ovf_r;

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Testbench for pipelined_bypass_adder: directed scenarios on a 4-stage
// instance plus a randomized regression over 1-, 2- and 4-stage instances
// checked against an arithmetic reference model.
module tb_pipelined_bypass_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pipelined_bypass_adder_if #(.WIDTH(32)) if4 ();
  pipelined_bypass_adder_if #(.WIDTH(32)) if2 ();
  pipelined_bypass_adder_if #(.WIDTH(32)) if1 ();

  pipelined_bypass_adder #(.WIDTH(32), .BLOCK(4), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave)
  );
  pipelined_bypass_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );
  pipelined_bypass_adder #(.WIDTH(32), .BLOCK(4), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  // Reference: {Ovf, Cout, Sum} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] full;
    longint      sres;
    logic        ovf;
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'b0, (sub ? 1'b1 : cin)};
    if (sub) sres = longint'($signed(a)) - longint'($signed(b));
    else     sres = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {ovf, full[32], full[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'hFFFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h00000000;
      default: return $urandom();
    endcase
  endfunction

  task automatic idle_all();
    if4.in_valid = 1'b0; if4.out_ready = 1'b1; if4.A = '0; if4.B = '0; if4.Cin = 1'b0; if4.Sub = 1'b0;
    if2.in_valid = 1'b0; if2.out_ready = 1'b1; if2.A = '0; if2.B = '0; if2.Cin = 1'b0; if2.Sub = 1'b0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.A = '0; if1.B = '0; if1.Cin = 1'b0; if1.Sub = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", if4.out_valid); end
    checks++; if (if4.Sum !== 32'h0) begin failures++; $display("[TB] FAIL reset_sum got=%h exp=0", if4.Sum); end
    checks++; if (if4.Cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got=%b exp=0", if4.Cout); end
    checks++; if (if4.Ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", if4.Ovf); end
    checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", if4.in_ready); end
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid_s2 got=%b exp=0", if2.out_valid); end
    checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid_s1 got=%b exp=0", if1.out_valid); end
  endtask

  task automatic test_bypass_chain();
    $display("[TB] test_bypass_chain");
    sync();
    if4.A = 32'hFFFFFFFF; if4.B = 32'h00000001; if4.Cin = 1'b0; if4.Sub = 1'b0; if4.in_valid = 1'b1;
    @(negedge clk);
    checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL chain_in_ready got=%b exp=1", if4.in_ready); end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if4.in_valid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL chain_early_valid cycle=%0d got=%b exp=0", i, if4.out_valid); end
      end else begin
        checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL chain_valid got=%b exp=1", if4.out_valid); end
        checks++; if (if4.Sum !== 32'h0) begin failures++; $display("[TB] FAIL chain_sum got=%h exp=00000000", if4.Sum); end
        checks++; if (if4.Cout !== 1'b1) begin failures++; $display("[TB] FAIL chain_cout got=%b exp=1", if4.Cout); end
        checks++; if (if4.Ovf !== 1'b0) begin failures++; $display("[TB] FAIL chain_ovf got=%b exp=0", if4.Ovf); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic        cv [2];
    logic [33:0] ev [2];
    $display("[TB] test_back_to_back");
    av[0] = 32'hAAAAAAAA; bv[0] = 32'h55555555; cv[0] = 1'b1; ev[0] = {1'b0, 1'b1, 32'h00000000};
    av[1] = 32'h7FFFFFFF; bv[1] = 32'h00000001; cv[1] = 1'b0; ev[1] = {1'b1, 1'b0, 32'h80000000};
    sync();
    for (int i = 0; i < 2; i++) begin
      if4.A = av[i]; if4.B = bv[i]; if4.Cin = cv[i]; if4.Sub = 1'b0; if4.in_valid = 1'b1;
      @(negedge clk);
      checks++; if (if4.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready beat=%0d got=%b exp=1", i, if4.in_ready); end
      sync();
    end
    if4.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_early_valid got=%b exp=0", if4.out_valid); end
    sync();
    @(negedge clk);
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_early_valid2 got=%b exp=0", if4.out_valid); end
    for (int i = 0; i < 2; i++) begin
      sync();
      @(negedge clk);
      checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid beat=%0d got=%b exp=1", i, if4.out_valid); end
      checks++; if ({if4.Ovf, if4.Cout, if4.Sum} !== ev[i]) begin failures++; $display("[TB] FAIL b2b_result beat=%0d got=%h exp=%h", i, {if4.Ovf, if4.Cout, if4.Sum}, ev[i]); end
    end
  endtask

  task automatic test_sub();
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [33:0] ev [2];
    $display("[TB] test_sub");
    av[0] = 32'h00000005; bv[0] = 32'h00000007; ev[0] = {1'b0, 1'b0, 32'hFFFFFFFE};
    av[1] = 32'h80000000; bv[1] = 32'h00000001; ev[1] = {1'b1, 1'b1, 32'h7FFFFFFF};
    sync();
    for (int i = 0; i < 2; i++) begin
      if4.A = av[i]; if4.B = bv[i]; if4.Cin = 1'b1; if4.Sub = 1'b1; if4.in_valid = 1'b1;
      sync();
    end
    if4.in_valid = 1'b0;
    if4.Sub = 1'b0;
    if4.Cin = 1'b0;
    sync();
    @(negedge clk);
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sub_early_valid got=%b exp=0", if4.out_valid); end
    for (int i = 0; i < 2; i++) begin
      sync();
      @(negedge clk);
      checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL sub_valid beat=%0d got=%b exp=1", i, if4.out_valid); end
      checks++; if ({if4.Ovf, if4.Cout, if4.Sum} !== ev[i]) begin failures++; $display("[TB] FAIL sub_result beat=%0d got=%h exp=%h", i, {if4.Ovf, if4.Cout, if4.Sum}, ev[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    int          sent;
    int          got;
    int          stall_cycles;
    $display("[TB] test_backpressure");
    sent = 0;
    got = 0;
    stall_cycles = 0;
    sync();
    for (int c = 0; c < 40 && got < 8; c++) begin
      if4.out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        if4.in_valid = 1'b1; if4.A = 32'(sent); if4.B = 32'(sent); if4.Cin = 1'b0; if4.Sub = 1'b0;
      end else begin
        if4.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 5 && c <= 7) begin
        checks++; if (if4.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_stall cycle=%0d got=%b exp=0", c, if4.in_ready); end
        checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_stall cycle=%0d got=%b exp=1", c, if4.out_valid); end
      end
      if (if4.out_valid === 1'b1) begin
        if (!if4.out_ready) stall_cycles++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL bp_unexpected cycle=%0d got=%h exp=none", c, if4.Sum);
        end else if ({if4.Ovf, if4.Cout, if4.Sum} !== {2'b00, exp_q[0]}) begin
          failures++; $display("[TB] FAIL bp_result cycle=%0d got=%h exp=%h", c, {if4.Ovf, if4.Cout, if4.Sum}, {2'b00, exp_q[0]});
        end
        if (if4.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (if4.in_valid && if4.in_ready) begin
        exp_q.push_back(32'(2 * sent));
        sent++;
      end
      sync();
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    checks++; if (got !== 8) begin failures++; $display("[TB] FAIL bp_delivered got=%0d exp=8", got); end
    checks++; if (stall_cycles !== 3) begin failures++; $display("[TB] FAIL bp_stall_cycles got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_midstream_reset();
    $display("[TB] test_midstream_reset");
    sync();
    for (int i = 0; i < 3; i++) begin
      if4.A = 32'(i + 10); if4.B = 32'(i); if4.Cin = 1'b0; if4.Sub = 1'b0; if4.in_valid = 1'b1;
      sync();
    end
    if4.in_valid = 1'b0;
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mrst_out_valid got=%b exp=0", if4.out_valid); end
    checks++; if (if4.Sum !== 32'h0) begin failures++; $display("[TB] FAIL mrst_sum got=%h exp=0", if4.Sum); end
    for (int i = 0; i < 6; i++) begin
      sync();
      @(negedge clk);
      checks++; if (if4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mrst_stale cycle=%0d got=%b exp=0", i, if4.out_valid); end
    end
    sync();
    if4.A = 32'h1; if4.B = 32'h1; if4.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if4.in_valid = 1'b0;
      @(negedge clk);
      if (i == 4) begin
        checks++; if (if4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mrst_new_valid got=%b exp=1", if4.out_valid); end
        checks++; if (if4.Sum !== 32'h2) begin failures++; $display("[TB] FAIL mrst_new_sum got=%h exp=00000002", if4.Sum); end
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] q4 [$];
    logic [33:0] q2 [$];
    logic [33:0] q1 [$];
    logic [33:0] obs;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        vin;
    logic        drain;
    $display("[TB] test_random");
    sync();
    for (int cyc = 0; cyc < 900; cyc++) begin
      drain = (cyc >= 800);
      vin = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      a = pick();
      b = pick();
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if4.in_valid = vin; if4.A = a; if4.B = b; if4.Cin = cin; if4.Sub = sub;
      if2.in_valid = vin; if2.A = a; if2.B = b; if2.Cin = cin; if2.Sub = sub;
      if1.in_valid = vin; if1.A = a; if1.B = b; if1.Cin = cin; if1.Sub = sub;
      if4.out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      if2.out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      if1.out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);

      if (if4.out_valid === 1'b1) begin
        obs = {if4.Ovf, if4.Cout, if4.Sum};
        checks++;
        if (q4.size() == 0) begin failures++; $display("[TB] FAIL rand_s4_unexpected got=%h exp=none", obs); end
        else if (obs !== q4[0]) begin failures++; $display("[TB] FAIL rand_s4_result got=%h exp=%h", obs, q4[0]); end
        if (if4.out_ready && q4.size() != 0) void'(q4.pop_front());
      end
      if (vin && if4.in_ready) q4.push_back(model(a, b, cin, sub));

      if (if2.out_valid === 1'b1) begin
        obs = {if2.Ovf, if2.Cout, if2.Sum};
        checks++;
        if (q2.size() == 0) begin failures++; $display("[TB] FAIL rand_s2_unexpected got=%h exp=none", obs); end
        else if (obs !== q2[0]) begin failures++; $display("[TB] FAIL rand_s2_result got=%h exp=%h", obs, q2[0]); end
        if (if2.out_ready && q2.size() != 0) void'(q2.pop_front());
      end
      if (vin && if2.in_ready) q2.push_back(model(a, b, cin, sub));

      if (if1.out_valid === 1'b1) begin
        obs = {if1.Ovf, if1.Cout, if1.Sum};
        checks++;
        if (q1.size() == 0) begin failures++; $display("[TB] FAIL rand_s1_unexpected got=%h exp=none", obs); end
        else if (obs !== q1[0]) begin failures++; $display("[TB] FAIL rand_s1_result got=%h exp=%h", obs, q1[0]); end
        if (if1.out_ready && q1.size() != 0) void'(q1.pop_front());
      end
      if (vin && if1.in_ready) q1.push_back(model(a, b, cin, sub));

      sync();
    end
    checks++; if (q4.size() !== 0) begin failures++; $display("[TB] FAIL rand_s4_drain got=%0d exp=0", q4.size()); end
    checks++; if (q2.size() !== 0) begin failures++; $display("[TB] FAIL rand_s2_drain got=%0d exp=0", q2.size()); end
    checks++; if (q1.size() !== 0) begin failures++; $display("[TB] FAIL rand_s1_drain got=%0d exp=0", q1.size()); end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_bypass_chain();
    test_back_to_back();
    test_sub();
    test_backpressure();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_bypass_adder.md
# pipelined_bypass_adder

Parametrised, pipelined carry-skip (bypass) adder/subtractor with valid/ready handshakes on input and output. The operand width is split into STAGES registered segments. Each segment is built from BLOCK-bit carry-skip groups, and the carry is registered between segments. This gives one result per cycle at a fixed latency. It is the next generation of the combinational bypass adder and sits on the datapath wherever a wide add/sub must close timing at full clock rate under downstream backpressure.

## Interface
- WIDTH, 32, operand and result width in bits; WIDTH % STAGES == 0
- BLOCK, 4, carry-skip group size in bits; (WIDTH/STAGES) % BLOCK == 0
- STAGES, 4, pipeline register stages (≥1); SEG = WIDTH/STAGES bits per segment
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add mode only)
- Sub  input  1  0: A+B+Cin; 1: A−B (Cin ignored)
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- Sum  output  WIDTH  result
- Cout  output  1  carry-out; in Sub mode 1 = no borrow (A ≥ B unsigned)
- Ovf  output  1  signed two's-complement overflow

## Operation
- Accept when in_valid && in_ready. Capture A, B, Cin and Sub into stage 0 along with a per-stage valid bit.
- Sub=1: effective B is ~B and effective carry-in is 1. Sub=0: effective B is B and effective carry-in is Cin.
- Stage s computes segment s (bits [s·SEG +: SEG]) from the registered carry of stage s−1. Stage 0 uses the effective carry-in.
  - Inside a segment, each BLOCK-bit group computes ripple sums.
  - The group carry-out is the bypass mux: if the group propagate (AND of a^b) is 1, the carry-out is the group carry-in; otherwise it is the ripple carry.
- Operand bits for later segments ride forward in skew registers. Sum bits already computed ride forward in deskew registers. All segments of one beat emerge aligned.
- Cout is the carry out of the MSB.
- Ovf = carry into MSB XOR carry out of MSB. The formula is the same in both modes.
- All arithmetic is modulo 2^WIDTH. There are no wider intermediate results beyond one carry bit per segment.
- Stall is global: advance = !out_valid || out_ready. When advance=0, every stage register holds.
- in_ready = advance. This is combinational from out_valid and out_ready, with no path from in_valid.
- Bubbles (in_valid=0 while advance=1) propagate as valid=0 stages. Beats are never dropped, duplicated or reordered.
- There is no FSM beyond the per-stage valid shift register. State per stage: empty (valid=0) or full (valid=1).

## Timing
- Reset: all stage valid bits, Sum, Cout and Ovf are 0; out_valid=0; in_ready=1 from the first cycle after reset.
- Latency: a beat accepted in cycle n presents out_valid=1 with its result in cycle n+STAGES, if there is no stall in between. Each stall cycle adds exactly one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Output hold: while out_valid=1 && out_ready=0, Sum, Cout and Ovf are stable and in_ready=0.
- Simultaneous pop and push in the same cycle (full pipeline, out_ready=1, in_valid=1) is legal. The pipe shifts with no bubble.
- rst asserted mid-stream: at that edge all in-flight beats are discarded and the outputs return to their reset values. rst has priority over advance.
- STAGES=1: the combinational carry-skip feeds a single output register; latency is 1.

## Test plan
- WIDTH=32, BLOCK=4, STAGES=4, out_ready=1. A=FFFFFFFF, B=00000001, Cin=0, Sub=0 accepted in cycle n → cycle n+4: Sum=00000000, Cout=1, Ovf=0. This exercises a full-length bypass chain across all segments.
- Back-to-back stream: AAAAAAAA+55555555 with Cin=1, then 7FFFFFFF+00000001 with Cin=0 → consecutive cycles give Sum=00000000, Cout=1, Ovf=0, then Sum=80000000, Cout=0, Ovf=1.
- Sub mode: A=00000005, B=00000007, Sub=1, Cin=1 (ignored) → Sum=FFFFFFFE, Cout=0, Ovf=0. Then A=80000000, B=00000001 → Sum=7FFFFFFF, Cout=1, Ovf=1.
- Backpressure: stream 8 beats A=i, B=i for i=0..7, with out_ready low for cycles 5–7 → in_ready low during the stall, output held stable, all 8 results 2i delivered in order with no loss.
- Mid-stream reset: 3 beats in flight, rst high for 1 cycle → next cycle out_valid=0 and Sum=0. No stale result ever appears. A new beat 00000001+00000001 gives Sum=00000002 after 4 cycles.
- Random regression across STAGES ∈ {1,2,4} with random out_ready → every result matches the reference model: {Cout,Sum} = A + (Sub ? ~B : B) + (Sub ? 1 : Cin), with Ovf checked against the signed reference.
